// File: rtl/cu_microseq.sv
// cu_microseq: hardwired micro-sequencer for an accumulator CPU.
// Fetch, decode and execute phases run as one FSM. All outputs are
// registered and are computed from the next state, so each output is
// aligned with the state it belongs to.
module cu_microseq #(
    parameter int IR_W   = 8,
    parameter int OPC_W  = 4,
    parameter int FLAG_W = 5,
    parameter int ZF_IDX = 4,
    parameter int CF_IDX = 3,
    parameter int NF_IDX = 1,
    parameter int CTRL_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [IR_W-1:0]   i_ir_data,
    input  logic [FLAG_W-1:0] i_flags,
    input  logic              i_mem_ready,
    input  logic              i_alu_done,
    input  logic              i_resume,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [3:0]        o_alu_op,
    output logic              o_IF_stage,
    output logic              o_ctrl_halt,
    output logic              o_instr_done,
    output logic [3:0]        o_state
);

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0, ST_F0 = 4'd1, ST_F1 = 4'd2, ST_F2 = 4'd3, ST_DEC = 4'd4,
        ST_E0 = 4'd5, ST_E1 = 4'd6, ST_E2 = 4'd7, ST_E3 = 4'd8, ST_E4 = 4'd9,
        ST_HALT = 4'd10
    } state_t;

    localparam logic [3:0] OP_LOAD = 4'h1, OP_STORE = 4'h2, OP_ADD = 4'h3, OP_SUB = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5, OP_OR    = 4'h6, OP_NOT = 4'h7, OP_SHL = 4'h8;
    localparam logic [3:0] OP_SHR  = 4'h9, OP_MPY   = 4'hA, OP_JMP = 4'hB, OP_JZ  = 4'hC;
    localparam logic [3:0] OP_JN   = 4'hD, OP_JC    = 4'hE, OP_HALT = 4'hF;

    localparam int B_PC_TO_MAR = 0, B_MEM_RD = 1, B_MBR_TO_IR = 2, B_PC_INC = 3;
    localparam int B_IRADDR_TO_MAR = 4, B_MBR_TO_ACC = 5, B_ACC_TO_MBR = 6, B_MEM_WR = 7;
    localparam int B_ALU_EN = 8, B_ALU_TO_ACC = 9, B_IRADDR_TO_PC = 10, B_MBR_TO_BR = 11;
    localparam int B_FLAG_UPD = 12;

    state_t                 state_r, next_s;
    logic                   armed_r;
    logic [3:0]             opc_r;
    logic [OPC_W-1:0]       ir_opc_s;
    logic [3:0]             dec_opc_s;
    logic [3:0]             cur_opc_s;
    logic [CTRL_W-1:0]      ctrl_r, ctrl_nx_s;
    logic [3:0]             alu_op_r, alu_op_nx_s;
    logic                   if_stage_r, halt_r, instr_done_r, instr_done_nx_s;
    logic                   unused_s;

    assign ir_opc_s = i_ir_data[IR_W-1 -: OPC_W];

    // Opcodes beyond the 16 defined ones behave as NOP.
    generate
        if (OPC_W > 4) begin : g_wide_opc
            assign dec_opc_s = (|ir_opc_s[OPC_W-1:4]) ? 4'h0 : ir_opc_s[3:0];
        end else begin : g_narrow_opc
            assign dec_opc_s = ir_opc_s;
        end
    endgenerate

    // In DEC the live opcode steers the first execute state; later states use the latched copy.
    assign cur_opc_s = (state_r == ST_DEC) ? dec_opc_s : opc_r;
    assign unused_s  = ^{i_ir_data, i_flags};

    function automatic logic is_jump(input logic [3:0] op);
        return (op == OP_JMP) || (op == OP_JZ) || (op == OP_JN) || (op == OP_JC);
    endfunction

    function automatic logic [3:0] alu_code(input logic [3:0] op);
        logic [3:0] code;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT, OP_SHL, OP_SHR, OP_MPY: code = op - 4'd2;
            default: code = 4'd0;
        endcase
        return code;
    endfunction

    function automatic logic [12:0] ctrl_of(input state_t st, input logic [3:0] op);
        logic [12:0] c;
        c = 13'd0;
        case (st)
            ST_F0: c[B_PC_TO_MAR] = 1'b1;
            ST_F1: c[B_MEM_RD] = 1'b1;
            ST_F2: begin
                c[B_MBR_TO_IR] = 1'b1;
                c[B_PC_INC]    = 1'b1;
            end
            ST_E0: begin
                if (is_jump(op)) begin
                    c[B_IRADDR_TO_PC] = 1'b1;
                end else begin
                    c[B_IRADDR_TO_MAR] = 1'b1;
                    c[B_ACC_TO_MBR]    = (op == OP_STORE);
                end
            end
            ST_E1: begin
                if (op == OP_STORE) c[B_MEM_WR] = 1'b1;
                else                c[B_MEM_RD] = 1'b1;
            end
            ST_E2: begin
                if (op == OP_LOAD) c[B_MBR_TO_ACC] = 1'b1;
                else               c[B_MBR_TO_BR]  = 1'b1;
            end
            ST_E3: c[B_ALU_EN] = 1'b1;
            ST_E4: begin
                c[B_ALU_TO_ACC] = 1'b1;
                c[B_FLAG_UPD]   = 1'b1;
            end
            default: c = 13'd0;
        endcase
        return c;
    endfunction

    // Next-state decision for the fetch/decode/execute sequence.
    always_comb begin
        next_s = ST_IDLE;
        case (state_r)
            ST_IDLE: next_s = armed_r ? ST_F0 : ST_IDLE;
            ST_F0:   next_s = ST_F1;
            ST_F1:   next_s = i_mem_ready ? ST_F2 : ST_F1;
            ST_F2:   next_s = ST_DEC;
            ST_DEC: begin
                case (dec_opc_s)
                    OP_LOAD, OP_STORE, OP_ADD, OP_SUB,
                    OP_AND, OP_OR, OP_MPY, OP_JMP:  next_s = ST_E0;
                    OP_NOT, OP_SHL, OP_SHR:         next_s = ST_E3;
                    OP_JZ:   next_s = i_flags[ZF_IDX] ? ST_E0 : ST_F0;
                    OP_JN:   next_s = i_flags[NF_IDX] ? ST_E0 : ST_F0;
                    OP_JC:   next_s = i_flags[CF_IDX] ? ST_E0 : ST_F0;
                    OP_HALT: next_s = ST_HALT;
                    default: next_s = ST_F0;
                endcase
            end
            ST_E0:   next_s = is_jump(opc_r) ? ST_F0 : ST_E1;
            ST_E1: begin
                if (!i_mem_ready)          next_s = ST_E1;
                else if (opc_r == OP_STORE) next_s = ST_F0;
                else                       next_s = ST_E2;
            end
            ST_E2:   next_s = (opc_r == OP_LOAD) ? ST_F0 : ST_E3;
            ST_E3:   next_s = ((opc_r == OP_MPY) && !i_alu_done) ? ST_E3 : ST_E4;
            ST_E4:   next_s = ST_F0;
            ST_HALT: next_s = i_resume ? ST_F0 : ST_HALT;
            default: next_s = ST_IDLE;
        endcase
    end

    // Output values for the state being entered on the next edge.
    always_comb begin
        ctrl_nx_s       = CTRL_W'(ctrl_of(next_s, cur_opc_s));
        alu_op_nx_s     = 4'd0;
        instr_done_nx_s = 1'b0;
        if ((next_s == ST_E3) || (next_s == ST_E4)) begin
            alu_op_nx_s = alu_code(cur_opc_s);
        end else begin
            alu_op_nx_s = 4'd0;
        end
        if ((next_s == ST_F0) && (state_r inside {ST_DEC, ST_E0, ST_E1, ST_E2, ST_E3, ST_E4})) begin
            instr_done_nx_s = 1'b1;
        end else if ((next_s == ST_HALT) && (state_r != ST_HALT)) begin
            instr_done_nx_s = 1'b1;
        end else begin
            instr_done_nx_s = 1'b0;
        end
    end

    // State, opcode latch and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r      <= ST_IDLE;
            armed_r      <= 1'b0;
            opc_r        <= 4'd0;
            ctrl_r       <= '0;
            alu_op_r     <= 4'd0;
            if_stage_r   <= 1'b0;
            halt_r       <= 1'b0;
            instr_done_r <= 1'b0;
        end else begin
            state_r      <= next_s;
            armed_r      <= 1'b1;
            opc_r        <= (state_r == ST_DEC) ? dec_opc_s : opc_r;
            ctrl_r       <= ctrl_nx_s;
            alu_op_r     <= alu_op_nx_s;
            if_stage_r   <= (next_s == ST_F0) || (next_s == ST_F1) || (next_s == ST_F2);
            halt_r       <= (next_s == ST_HALT);
            instr_done_r <= instr_done_nx_s;
        end
    end

    assign o_ctrl       = ctrl_r;
    assign o_alu_op     = alu_op_r;
    assign o_IF_stage   = if_stage_r;
    assign o_ctrl_halt  = halt_r;
    assign o_instr_done = instr_done_r;
    assign o_state      = state_r;

endmodule

// File: tb/tb_cu_microseq.sv
// Testbench for cu_microseq: scenario tasks plus randomized instruction
// streams, checked cycle by cycle against a per-instruction step table.
module tb_cu_microseq;

    localparam int W_NONE = 0, W_MEM = 1, W_ALU = 2, W_RES = 3;

    typedef struct {
        logic [3:0]  st;
        logic [15:0] ctrl;
        logic [3:0]  alu;
        int          w;
    } step_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  ir = 8'h00;
    logic [4:0]  flags = 5'd0;
    logic        mem_ready = 1'b0, alu_done = 1'b0, resume = 1'b0;
    logic [15:0] ctrl;
    logic [3:0]  alu_op, state;
    logic        if_stage, halt, done;

    int vectors = 0;
    int miscompares = 0;
    bit done_next = 1'b0;

    always #5 clk = ~clk;

    cu_microseq dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_ir_data(ir), .i_flags(flags),
        .i_mem_ready(mem_ready), .i_alu_done(alu_done), .i_resume(resume),
        .o_ctrl(ctrl), .o_alu_op(alu_op), .o_IF_stage(if_stage),
        .o_ctrl_halt(halt), .o_instr_done(done), .o_state(state)
    );

    function automatic logic [3:0] alu_code(input logic [3:0] op);
        case (op)
            4'h3: return 4'd1;
            4'h4: return 4'd2;
            4'h5: return 4'd3;
            4'h6: return 4'd4;
            4'h7: return 4'd5;
            4'h8: return 4'd6;
            4'h9: return 4'd7;
            4'hA: return 4'd8;
            default: return 4'd0;
        endcase
    endfunction

    // Runs one instruction from its F0 negedge, checking every cycle. Ends on the next F0 negedge,
    // or returns early right after checking step index stop_at.
    task automatic exec_instr(input string tag, input logic [7:0] ir_v, input logic [4:0] fl_v,
                              input int mem_lat, input int alu_lat, input int res_lat, input int stop_at);
        step_t q[$];
        logic [3:0]  op;
        logic [3:0]  ac;
        logic [26:0] exp_v, got_v;
        logic        db;
        bit          taken;
        op = ir_v[7:4];
        ac = alu_code(op);
        q.push_back('{4'd1, 16'h0001, 4'd0, W_NONE});
        q.push_back('{4'd2, 16'h0002, 4'd0, W_MEM});
        q.push_back('{4'd3, 16'h000C, 4'd0, W_NONE});
        q.push_back('{4'd4, 16'h0000, 4'd0, W_NONE});
        taken = (op == 4'hB) || (op == 4'hC && fl_v[4]) || (op == 4'hD && fl_v[1]) || (op == 4'hE && fl_v[3]);
        case (op)
            4'h1: begin
                q.push_back('{4'd5, 16'h0010, 4'd0, W_NONE});
                q.push_back('{4'd6, 16'h0002, 4'd0, W_MEM});
                q.push_back('{4'd7, 16'h0020, 4'd0, W_NONE});
            end
            4'h2: begin
                q.push_back('{4'd5, 16'h0050, 4'd0, W_NONE});
                q.push_back('{4'd6, 16'h0080, 4'd0, W_MEM});
            end
            4'h3, 4'h4, 4'h5, 4'h6, 4'hA: begin
                q.push_back('{4'd5, 16'h0010, 4'd0, W_NONE});
                q.push_back('{4'd6, 16'h0002, 4'd0, W_MEM});
                q.push_back('{4'd7, 16'h0800, 4'd0, W_NONE});
                q.push_back('{4'd8, 16'h0100, ac, (op == 4'hA) ? W_ALU : W_NONE});
                q.push_back('{4'd9, 16'h1200, ac, W_NONE});
            end
            4'h7, 4'h8, 4'h9: begin
                q.push_back('{4'd8, 16'h0100, ac, W_NONE});
                q.push_back('{4'd9, 16'h1200, ac, W_NONE});
            end
            4'hF: q.push_back('{4'd10, 16'h0000, 4'd0, W_RES});
            default: begin
                if (taken) q.push_back('{4'd5, 16'h0400, 4'd0, W_NONE});
            end
        endcase
        for (int i = 0; i < q.size(); i++) begin
            int waited;
            bit adv;
            waited = 0;
            adv = 1'b0;
            while (!adv) begin
                if (i == 0 && waited == 0)            db = done_next;
                else if (q[i].st == 4'd10 && waited == 0) db = 1'b1;
                else                                  db = 1'b0;
                exp_v = {q[i].st, q[i].ctrl, q[i].alu, (q[i].st >= 4'd1 && q[i].st <= 4'd3),
                         (q[i].st == 4'd10), db};
                got_v = {state, ctrl, alu_op, if_stage, halt, done};
                vectors++;
                if (got_v !== exp_v) begin
                    miscompares++;
                    $display("FAIL %s step%0d cyc%0d: got st=%0d ctrl=%h alu=%0d if=%b halt=%b done=%b, expected st=%0d ctrl=%h alu=%0d if=%b halt=%b done=%b",
                             tag, i, waited, state, ctrl, alu_op, if_stage, halt, done,
                             exp_v[26:23], exp_v[22:7], exp_v[6:3], exp_v[2], exp_v[1], exp_v[0]);
                end
                ir        = (q[i].st == 4'd4) ? ir_v : 8'($urandom);
                flags     = (q[i].st == 4'd4) ? fl_v : 5'($urandom);
                mem_ready = (q[i].w == W_MEM) ? (waited >= mem_lat) : 1'($urandom);
                alu_done  = (q[i].w == W_ALU) ? (waited >= alu_lat) : 1'($urandom);
                resume    = (q[i].w == W_RES) && (waited >= res_lat);
                if (i == stop_at) begin
                    mem_ready = 1'b0;
                    return;
                end
                case (q[i].w)
                    W_MEM:   adv = mem_ready;
                    W_ALU:   adv = alu_done;
                    W_RES:   adv = resume;
                    default: adv = 1'b1;
                endcase
                waited++;
                @(negedge clk);
            end
        end
        resume = 1'b0;
        done_next = (op != 4'hF);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        mem_ready = 1'b0; alu_done = 1'b0; resume = 1'b0;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if ({state, ctrl, alu_op, if_stage, halt, done} !== 27'd0) begin
            miscompares++;
            $display("FAIL reset_hold: got st=%0d ctrl=%h alu=%0d flags=%b%b%b, expected all 0",
                     state, ctrl, alu_op, if_stage, halt, done);
        end
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if ({state, ctrl, alu_op, if_stage, halt, done} !== 27'd0) begin
            miscompares++;
            $display("FAIL reset_idle: got st=%0d ctrl=%h, expected IDLE st=0 ctrl=0000", state, ctrl);
        end
        @(negedge clk);
        done_next = 1'b0;
    endtask

    task automatic test_fetch_nop;
        exec_instr("nop_a", 8'h00, 5'd0, 0, 0, 0, -1);
        exec_instr("nop_b", 8'h00, 5'd0, 0, 0, 0, -1);
    endtask

    task automatic test_alu_ops;
        exec_instr("add", 8'h3A, 5'd0, 0, 0, 0, -1);
        exec_instr("mpy", 8'hA5, 5'd0, 0, 3, 0, -1);
        exec_instr("not", 8'h70, 5'd0, 0, 0, 0, -1);
    endtask

    task automatic test_jcc;
        exec_instr("jz_taken", 8'hC7, 5'b10000, 0, 0, 0, -1);
        exec_instr("jz_untaken", 8'hC7, 5'b00000, 0, 0, 0, -1);
        exec_instr("jn_taken", 8'hD1, 5'b00010, 0, 0, 0, -1);
        exec_instr("jc_untaken", 8'hE1, 5'b10010, 0, 0, 0, -1);
    endtask

    task automatic test_stall_halt;
        exec_instr("f1_stall", 8'h00, 5'd0, 5, 0, 0, -1);
        exec_instr("halt", 8'hF0, 5'd0, 0, 0, 4, -1);
        exec_instr("after_halt", 8'h2C, 5'd0, 2, 0, 0, -1);
    endtask

    // F0-to-F0 cycle counts measured straight from the DUT state output.
    task automatic test_latency;
        logic [7:0] irs [7];
        int         lat [7];
        irs = '{8'h00, 8'h15, 8'h25, 8'h35, 8'h75, 8'hB5, 8'hC5};
        lat = '{4, 7, 6, 9, 6, 5, 4};
        for (int k = 0; k < 7; k++) begin
            int cnt;
            ir = irs[k]; flags = 5'd0; mem_ready = 1'b1; alu_done = 1'b0; resume = 1'b0;
            cnt = 0;
            do begin
                @(negedge clk);
                cnt++;
            end while (state !== 4'd1 && cnt < 30);
            vectors++;
            if (cnt != lat[k]) begin
                miscompares++;
                $display("FAIL latency_%h: got %0d cycles, expected %0d", irs[k], cnt, lat[k]);
            end
        end
        done_next = 1'b1;
    endtask

    task automatic test_reset_mid;
        exec_instr("load_abort", 8'h1F, 5'd0, 50, 0, 0, 5);
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({state, ctrl, alu_op, if_stage, halt, done} !== 27'd0) begin
            miscompares++;
            $display("FAIL reset_async: got st=%0d ctrl=%h alu=%0d, expected all 0", state, ctrl, alu_op);
        end
        test_reset();
        exec_instr("load_restart", 8'h1F, 5'd0, 1, 0, 0, -1);
    endtask

    task automatic test_random;
        for (int n = 0; n < 60; n++) begin
            exec_instr("rand", 8'($urandom), 5'($urandom), int'($urandom_range(0, 3)),
                       int'($urandom_range(0, 4)), int'($urandom_range(0, 3)), -1);
        end
    endtask

    initial begin
        test_reset();
        test_fetch_nop();
        test_alu_ops();
        test_jcc();
        test_stall_halt();
        test_latency();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
